// File: rtl/pe_array_seq.sv
// pe_array_seq
//   Job sequencer between the host/DMA operand stream and the PE array
//   overlay. One job is: accept PE_NUM*LOAD_NUM operand words from the host
//   and forward them to the array as one gap-free burst, wait a fixed compute
//   window, pulse the array load strobe DRAIN_NUM times, and return the
//   drained results on a valid-qualified stream (no backpressure).
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, active-high (wins over every input)
//   start     in   1-cycle job request, sampled only while idle
//   s_valid   in   host operand word valid
//   s_data    in   host operand word
//   s_ready   out  operand word accepted (load phase only)
//   ov_din_v  out  array din_overlay_v (registered, 1-cycle latency)
//   ov_din    out  array din_overlay, zero whenever ov_din_v is low
//   ov_load   out  array load strobe
//   ov_dout   in   array dout_overlay
//   m_valid   out  result word valid (ov_load delayed one cycle)
//   m_data    out  result word, zero whenever m_valid is low
//   busy      out  high in every state except idle
//   done      out  1-cycle pulse at job completion
//   err       out  sticky burst-gap error, cleared by rst or next start
module pe_array_seq #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PE_NUM      = 8,
  parameter int unsigned LOAD_NUM    = 64,
  parameter int unsigned COMPUTE_CYC = 256,
  parameter int unsigned DRAIN_NUM   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ov_din_v,
  output logic [DATA_W-1:0] ov_din,
  output logic              ov_load,
  input  logic [DATA_W-1:0] ov_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned BURST = PE_NUM * LOAD_NUM;
  localparam int unsigned WC_W  = $clog2(BURST + 1);
  localparam int unsigned TC_W  = $clog2(COMPUTE_CYC + 1);
  localparam int unsigned DC_W  = $clog2(DRAIN_NUM + 1);

  localparam logic [WC_W-1:0] WORD_LAST  = WC_W'(BURST - 1);
  localparam logic [TC_W-1:0] WAIT_LAST  = TC_W'(COMPUTE_CYC - 1);
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WC_W-1:0] word_cnt;
  logic [TC_W-1:0] wait_cnt;
  logic [DC_W-1:0] drain_cnt;

  logic job_go;
  logic xfer;
  logic gap;
  logic burst_end;
  logic wait_end;
  logic drain_end;

  assign job_go    = (state == S_IDLE) && start;
  assign xfer      = (state == S_LOAD) && s_valid;
  // The array numbers PEs with a contiguous-valid counter, so any hole after
  // the first word would misroute the rest of the burst: abort instead.
  assign gap       = (state == S_LOAD) && !s_valid && (word_cnt != '0);
  assign burst_end = xfer && (word_cnt == WORD_LAST);
  // WAIT is entered on the same edge that raises the last ov_din_v, so
  // COMPUTE_CYC cycles in WAIT put the first ov_load exactly COMPUTE_CYC
  // cycles after the last burst word seen by the array.
  assign wait_end  = (state == S_WAIT) && (wait_cnt == WAIT_LAST);
  assign drain_end = (state == S_DRAIN) && (drain_cnt == DRAIN_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        if (gap) begin
          state_nx = S_IDLE;
        end else if (burst_end) begin
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_end) begin
          state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_end) begin
          state_nx = S_FLUSH;
        end
      end
      S_FLUSH: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    s_ready = (state == S_LOAD);
    ov_load = (state == S_DRAIN);
    busy    = (state != S_IDLE);
    done    = (state == S_DONE);
    // The array already registers its output, so the result word is taken
    // straight from ov_dout in the cycle m_valid is high.
    m_data  = m_valid ? ov_dout : '0;
  end

  // Counters, registered data path and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt  <= '0;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      ov_din_v  <= 1'b0;
      ov_din    <= '0;
      m_valid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      ov_din_v <= xfer;
      ov_din   <= xfer ? s_data : '0;
      m_valid  <= (state == S_DRAIN);

      if (job_go || gap) begin
        word_cnt <= '0;
      end else if (xfer) begin
        word_cnt <= burst_end ? '0 : word_cnt + WC_W'(1);
      end

      if (state == S_WAIT) begin
        wait_cnt <= wait_end ? '0 : wait_cnt + TC_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      if (state == S_DRAIN) begin
        drain_cnt <= drain_end ? '0 : drain_cnt + DC_W'(1);
      end else begin
        drain_cnt <= '0;
      end

      if (job_go) begin
        err <= 1'b0;
      end else if (gap) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pe_array_seq.sv
// tb_pe_array_seq
//   Directed bench for pe_array_seq with a small PE array model that
//   accumulates the burst per PE (contiguous-valid indexing) and returns
//   tagged result words on ov_dout after each load strobe.
module tb_pe_array_seq;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned PE_NUM      = 8;
  localparam int unsigned LOAD_NUM    = 64;
  localparam int unsigned COMPUTE_CYC = 256;
  localparam int unsigned DRAIN_NUM   = 4;
  localparam int unsigned BURST       = 512;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              ov_din_v;
  logic [DATA_W-1:0] ov_din;
  logic              ov_load;
  logic [DATA_W-1:0] ov_dout = 32'hDEAD_BEEF;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  pe_array_seq #(
    .DATA_W(DATA_W),
    .PE_NUM(PE_NUM),
    .LOAD_NUM(LOAD_NUM),
    .COMPUTE_CYC(COMPUTE_CYC),
    .DRAIN_NUM(DRAIN_NUM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .ov_din_v(ov_din_v),
    .ov_din(ov_din),
    .ov_load(ov_load),
    .ov_dout(ov_dout),
    .m_valid(m_valid),
    .m_data(m_data),
    .busy(busy),
    .done(done),
    .err(err)
  );

  // Array model
  logic        model_clr = 1'b0;
  int unsigned stream_cnt = 0;
  int unsigned pidx;
  int unsigned drain_idx = 0;
  logic [31:0] pe_sum [PE_NUM];

  always @(posedge clk) begin
    if (ov_din_v) begin
      pidx = stream_cnt / LOAD_NUM;
      if (pidx < PE_NUM) pe_sum[pidx] <= pe_sum[pidx] + ov_din;
      stream_cnt <= stream_cnt + 1;
    end else begin
      stream_cnt <= 0;
    end
    if (model_clr) begin
      for (int p = 0; p < PE_NUM; p++) pe_sum[p] <= '0;
    end
    if (ov_load) begin
      ov_dout   <= 32'hA000_0000 + drain_idx;
      drain_idx <= drain_idx + 1;
    end else begin
      ov_dout   <= 32'hDEAD_BEEF;
      drain_idx <= 0;
    end
  end

  int mv_count = 0;
  int ld_count = 0;
  always @(negedge clk) begin
    if (m_valid) mv_count++;
    if (ov_load) ld_count++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    model_clr = 1'b1;
    tick();
    start = 1'b0;
    model_clr = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", s_ready, 1);
    check("start_err", err, 0);
    check("start_dinv", ov_din_v, 0);
  endtask

  task automatic send_burst(input logic [31:0] base, input int unsigned pre_gap,
                            input int unsigned start_at);
    s_valid = 1'b0;
    for (int unsigned g = 0; g < pre_gap; g++) begin
      tick();
      check("gap_ready", s_ready, 1);
      check("gap_dinv", ov_din_v, 0);
      check("gap_err", err, 0);
    end
    for (int unsigned i = 0; i < BURST; i++) begin
      s_valid = 1'b1;
      s_data  = base + i;
      start   = (i == start_at);
      tick();
      check("burst_dinv", ov_din_v, 1);
      check("burst_din", ov_din, base + i);
      check("burst_ready", s_ready, (i < BURST - 1) ? 1 : 0);
    end
    s_valid = 1'b0;
    s_data  = '0;
    start   = 1'b0;
  endtask

  task automatic wait_window(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      tick();
      check("wait_load", ov_load, 0);
      check("wait_dinv", ov_din_v, 0);
      check("wait_din", ov_din, 0);
      check("wait_mvalid", m_valid, 0);
      check("wait_mdata", m_data, 0);
      check("wait_busy", busy, 1);
    end
  endtask

  task automatic drain_done(input logic start_in_drain);
    tick();
    check("d1_load", ov_load, 1);
    check("d1_mvalid", m_valid, 0);
    for (int unsigned k = 0; k < DRAIN_NUM - 1; k++) begin
      start = start_in_drain;
      tick();
      check("drain_load", ov_load, 1);
      check("drain_mvalid", m_valid, 1);
      check("drain_mdata", m_data, 32'hA000_0000 + k);
    end
    start = 1'b0;
    tick();
    check("flush_load", ov_load, 0);
    check("flush_mvalid", m_valid, 1);
    check("flush_mdata", m_data, 32'hA000_0003);
    check("flush_done", done, 0);
    check("flush_busy", busy, 1);
    tick();
    check("done_pulse", done, 1);
    check("done_mvalid", m_valid, 0);
    check("done_mdata", m_data, 0);
    check("done_busy", busy, 1);
    tick();
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_err", err, 0);
    check("idle_ready", s_ready, 0);
  endtask

  // PE p receives words base+64p .. base+64p+63: sum = 64*base + 4096*p + 2016
  task automatic check_pe(input logic [31:0] base);
    for (int unsigned p = 0; p < PE_NUM; p++) begin
      check("pe_sum", pe_sum[p], base * 64 + p * 4096 + 2016);
    end
  endtask

  task automatic full_job(input logic [31:0] base, input int unsigned pre_gap);
    do_start();
    send_burst(base, pre_gap, BURST);
    wait_window(COMPUTE_CYC - 1);
    drain_done(1'b0);
    check_pe(base);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int mv0;
    int ld0;
    rst = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    tick();
    tick();
    check("rst_flags", {ov_din_v, ov_load, m_valid, busy, done, err, s_ready}, 0);
    check("rst_din", ov_din, 0);
    check("rst_mdata", m_data, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_quiet", {busy, s_ready, ov_load, m_valid}, 0);
    end

    // T1 nominal
    mv0 = mv_count;
    ld0 = ld_count;
    full_job(32'h0, 0);
    check("t1_mvalid_cnt", mv_count - mv0, 4);
    check("t1_load_cnt", ld_count - ld0, 4);

    // T2 late data
    full_job(32'h1000, 10);

    // T3 gap abort after word 100, then a clean job
    do_start();
    for (int unsigned i = 0; i <= 100; i++) begin
      s_valid = 1'b1;
      s_data  = 32'h5000 + i;
      tick();
      check("t3_dinv", ov_din_v, 1);
      check("t3_din", ov_din, 32'h5000 + i);
    end
    s_valid = 1'b0;
    s_data  = '0;
    ld0 = ld_count;
    tick();
    check("t3_abort_dinv", ov_din_v, 0);
    check("t3_abort_din", ov_din, 0);
    check("t3_abort_err", err, 1);
    check("t3_abort_busy", busy, 0);
    check("t3_abort_ready", s_ready, 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("t3_quiet", {ov_load, busy, err}, 3'b001);
    end
    check("t3_no_load", ld_count - ld0, 0);
    full_job(32'h7000, 0);

    // T4 reset in the compute window
    do_start();
    send_burst(32'h9000, 0, BURST);
    wait_window(50);
    mv0 = mv_count;
    ld0 = ld_count;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_flags", {ov_din_v, ov_load, m_valid, busy, done, err, s_ready}, 0);
    check("t4_din", ov_din, 0);
    check("t4_mdata", m_data, 0);
    for (int k = 0; k < 300; k++) begin
      tick();
      check("t4_quiet", {ov_load, m_valid, busy}, 0);
    end
    check("t4_no_mvalid", mv_count - mv0, 0);
    check("t4_no_load", ld_count - ld0, 0);

    // T5 start together with rst, then starts during LOAD and DRAIN
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("t5_rst_start_busy", busy, 0);
    check("t5_rst_start_ready", s_ready, 0);
    tick();
    check("t5_stay_idle", {busy, s_ready}, 0);
    do_start();
    send_burst(32'hB000, 0, 200);
    wait_window(COMPUTE_CYC - 1);
    drain_done(1'b1);
    check_pe(32'hB000);
    tick();
    check("t5_after_busy", busy, 0);

    // T6 back-to-back jobs, start on the cycle after done
    mv0 = mv_count;
    full_job(32'hC000, 0);
    full_job(32'hD000, 0);
    check("t6_mvalid_cnt", mv_count - mv0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
